apb_rr_arbiter: RTL and testbench
=================================

Name: apb_rr_arbiter

Overview:
- N-master to 1-slave APB3 arbiter; parametrised successor of the fixed 3-port MDIO/CPU/APB arbiter in ctrl_sys.
- Sits between the register masters (MDIO, CPU, APB bridge, debug) and the group register request bus.
- Adds runtime-selectable fixed-priority or round-robin grant, a registered per-transaction timeout counter, a registered response stage, and slave-error reporting.

Parameters:
- NUM_MST, 3, number of masters; legal range 2..8.
- ADDR_WIDTH, 21, address width.
- DATA_WIDTH, 16, data width.
- TO_WIDTH, 16, width of the timeout counter and of cfg_timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cfg_timeout  in  TO_WIDTH  access-phase timeout in cycles; 0 disables the timeout
- cfg_rr_en  in  1  1 = round-robin, 0 = fixed priority (index 0 highest)
- mst_paddr  in  NUM_MST*ADDR_WIDTH  master addresses; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- mst_psel  in  NUM_MST  per-master psel
- mst_penable  in  NUM_MST  per-master penable
- mst_pwrite  in  NUM_MST  per-master pwrite
- mst_pwdata  in  NUM_MST*DATA_WIDTH  write data, sliced as mst_paddr
- mst_pready  out  NUM_MST  per-master pready, registered
- mst_prdata  out  DATA_WIDTH  shared read data, registered
- mst_pslverr  out  NUM_MST  per-master pslverr, registered; present only with ARB_PSLVERR_EN
- req_addr  out  ADDR_WIDTH  downstream address
- req_write  out  1  downstream write
- req_sel  out  1  downstream select
- req_wdata  out  DATA_WIDTH  downstream write data
- req_ready  in  1  downstream completion
- req_rdata  in  DATA_WIDTH  downstream read data
- stat_timeout  out  1  one-cycle pulse when a transaction times out
- stat_gnt_id  out  clog2(NUM_MST)  index of the currently or last granted master

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer last = NUM_MST-1, so master 0 is first in line.
  - Timeout counter 0.
- Request: valid[i] = mst_psel[i] & mst_penable[i] & ~mst_pready[i]. The last term blocks re-grant during the response cycle.
- FSM states are IDLE, ACCESS and RESP; all outputs are registered.
- IDLE:
  - If any valid bit is set, choose the winner, latch its paddr/pwrite/pwdata into registers, set gnt and stat_gnt_id, clear the counter, and go to ACCESS.
  - Fixed priority (cfg_rr_en=0): the lowest valid index wins.
  - Round-robin (cfg_rr_en=1): search from last+1 modulo NUM_MST; last is updated to the winner on grant.
  - cfg_rr_en is sampled only in IDLE.
- ACCESS:
  - req_sel=1 and req_addr/req_write/req_wdata driven from the latched values.
  - The counter increments by 1 every cycle and saturates at all-ones.
  - If req_ready=1: capture req_rdata into mst_prdata and go to RESP with err=0.
  - Otherwise, if cfg_timeout!=0 and the counter reaches cfg_timeout: mst_prdata=0, stat_timeout pulses, go to RESP with err=1.
  - If req_ready and timeout occur in the same cycle, req_ready wins (no error).
- RESP:
  - mst_pready[gnt]=1 for exactly one cycle, plus mst_pslverr[gnt]=err.
  - req_sel=0; return to IDLE.
  - mst_prdata holds its value until the next capture.
- Latency: penable seen at cycle T gives req_sel at T+1. If req_ready is seen at cycle R, mst_pready is asserted at R+1. Minimum transfer is 3 cycles from penable.
- A master dropping psel during ACCESS is not an abort: the transaction completes and pready still pulses.
- Non-granted masters see pready=0 and remain pending. A master that becomes valid during ACCESS is considered at the next IDLE.
- Reset mid-transaction: immediate return to IDLE; no pready is issued; all latched fields clear.
- req_ready while in IDLE or RESP is ignored.

Optional Feature:
- Macro: ARB_PSLVERR_EN.
- Defined: the mst_pslverr port exists; a timeout asserts pslverr=1 alongside pready with prdata=0.
- Undefined: the port is absent; a timeout completes with pready only and prdata=0. All other behaviour is identical, including stat_timeout.

Test Plan:
- Single read: m1 reads 0x00123, slave gives req_ready after 2 ACCESS cycles with rdata=0xA5A5 -> mst_pready[1] pulses once, mst_prdata=0xA5A5, req_addr=0x00123 during ACCESS, pslverr=0.
- Fixed priority: m0, m1 and m2 all valid with cfg_rr_en=0 -> grant order 0, 0, ... while m0 re-requests; m2 served only after m0 and m1 go idle.
- Round-robin: three masters continuously valid with cfg_rr_en=1 and req_ready=1 immediately -> stat_gnt_id sequence 0, 1, 2, 0, one transfer per 3 cycles.
- Timeout: cfg_timeout=5, req_ready held 0 -> req_sel high for 5 cycles, stat_timeout pulse, then pready with pslverr=1 and prdata=0x0000. With cfg_timeout=0 the arbiter waits indefinitely.
- Same-cycle boundary: req_ready asserted exactly on the cycle the counter reaches cfg_timeout -> normal completion, pslverr=0, no stat_timeout.
- Reset mid-ACCESS: rstn low during ACCESS -> all outputs 0 asynchronously, no pready. After release, a pending m2 is granted first in round-robin order after m0/m1 checks, with the pointer reset.

Source files
------------

// File: rtl/apb_rr_arbiter.sv
// N-master to 1-slave APB3 arbiter: fixed-priority or round-robin grant, access timeout,
// registered response. Define ARB_PSLVERR_EN to add the per-master mst_pslverr port.
module apb_rr_arbiter #(
  parameter int NUM_MST    = 3,
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 16,
  parameter int TO_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [TO_WIDTH-1:0]           cfg_timeout,
  input  logic                          cfg_rr_en,
  input  logic [NUM_MST*ADDR_WIDTH-1:0] mst_paddr,
  input  logic [NUM_MST-1:0]            mst_psel,
  input  logic [NUM_MST-1:0]            mst_penable,
  input  logic [NUM_MST-1:0]            mst_pwrite,
  input  logic [NUM_MST*DATA_WIDTH-1:0] mst_pwdata,
  output logic [NUM_MST-1:0]            mst_pready,
  output logic [DATA_WIDTH-1:0]         mst_prdata,
`ifdef ARB_PSLVERR_EN
  output logic [NUM_MST-1:0]            mst_pslverr,
`endif
  output logic [ADDR_WIDTH-1:0]         req_addr,
  output logic                          req_write,
  output logic                          req_sel,
  output logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic                          req_ready,
  input  logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          stat_timeout,
  output logic [$clog2(NUM_MST)-1:0]    stat_gnt_id
);
  localparam int GW = $clog2(NUM_MST);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_nx;
  logic [GW-1:0]         last, last_nx, gnt_nx, cand;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx, prdata_nx;
  logic                  write_nx, sel_nx, to_nx, found;
  logic [TO_WIDTH-1:0]   cnt, cnt_nx, cnt_inc;
  logic [NUM_MST-1:0]    valid, onehot, pready_nx;
`ifdef ARB_PSLVERR_EN
  logic [NUM_MST-1:0]    pslverr_nx;
`endif

  logic [ADDR_WIDTH-1:0] paddr_a [NUM_MST];
  logic [DATA_WIDTH-1:0] pwdata_a [NUM_MST];

  for (genvar g = 0; g < NUM_MST; g++) begin : g_unpack
    assign paddr_a[g]  = mst_paddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign pwdata_a[g] = mst_pwdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // pready masks the master being answered so its held request is not re-granted
  assign valid   = mst_psel & mst_penable & ~mst_pready;
  assign onehot  = NUM_MST'(1) << stat_gnt_id;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + TO_WIDTH'(1);

  always_comb begin
    state_nx  = state;
    last_nx   = last;
    gnt_nx    = stat_gnt_id;
    addr_nx   = req_addr;
    write_nx  = req_write;
    wdata_nx  = req_wdata;
    sel_nx    = req_sel;
    cnt_nx    = cnt;
    prdata_nx = mst_prdata;
    pready_nx = '0;
    to_nx     = 1'b0;
    found     = 1'b0;
    cand      = '0;
`ifdef ARB_PSLVERR_EN
    pslverr_nx = '0;
`endif
    case (state)
      IDLE: begin
        for (int unsigned k = 0; k < NUM_MST; k++) begin
          cand = cfg_rr_en ? GW'((32'(last) + 32'd1 + k) % NUM_MST) : GW'(k);
          if (!found && valid[cand]) begin
            found    = 1'b1;
            gnt_nx   = cand;
            addr_nx  = paddr_a[cand];
            write_nx = mst_pwrite[cand];
            wdata_nx = pwdata_a[cand];
          end
        end
        if (found) begin
          if (cfg_rr_en) last_nx = gnt_nx;
          sel_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        cnt_nx = cnt_inc;
        if (req_ready) begin
          prdata_nx = req_rdata;
          pready_nx = onehot;
          sel_nx    = 1'b0;
          state_nx  = RESP;
        end else if (cfg_timeout != '0 && cnt_inc >= cfg_timeout) begin
          prdata_nx = '0;
          pready_nx = onehot;
          to_nx     = 1'b1;
          sel_nx    = 1'b0;
          state_nx  = RESP;
`ifdef ARB_PSLVERR_EN
          pslverr_nx = onehot;
`endif
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last         <= GW'(NUM_MST-1);
      stat_gnt_id  <= '0;
      req_addr     <= '0;
      req_write    <= 1'b0;
      req_wdata    <= '0;
      req_sel      <= 1'b0;
      cnt          <= '0;
      mst_prdata   <= '0;
      mst_pready   <= '0;
      stat_timeout <= 1'b0;
`ifdef ARB_PSLVERR_EN
      mst_pslverr  <= '0;
`endif
    end else begin
      state        <= state_nx;
      last         <= last_nx;
      stat_gnt_id  <= gnt_nx;
      req_addr     <= addr_nx;
      req_write    <= write_nx;
      req_wdata    <= wdata_nx;
      req_sel      <= sel_nx;
      cnt          <= cnt_nx;
      mst_prdata   <= prdata_nx;
      mst_pready   <= pready_nx;
      stat_timeout <= to_nx;
`ifdef ARB_PSLVERR_EN
      mst_pslverr  <= pslverr_nx;
`endif
    end
  end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: vector table, directed corner sequences and random
// transactions checked against a transaction-level arbitration model.
module tb_apb_rr_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cfg_timeout;
  logic        cfg_rr_en;
  logic [62:0] mst_paddr;
  logic [2:0]  mst_psel, mst_penable, mst_pwrite;
  logic [47:0] mst_pwdata;
  logic [2:0]  mst_pready;
  logic [15:0] mst_prdata;
`ifdef ARB_PSLVERR_EN
  logic [2:0]  mst_pslverr;
`endif
  logic [20:0] req_addr;
  logic        req_write, req_sel, req_ready, stat_timeout;
  logic [15:0] req_wdata, req_rdata;
  logic [1:0]  stat_gnt_id;

  int n_chk = 0;
  int n_fail = 0;

  logic [2:0]  pending;
  int          mptr;
  logic [20:0] maddr [3];
  logic        mwrite [3];
  logic [15:0] mwdata [3];

  always #5 clk = ~clk;

  apb_rr_arbiter #(.NUM_MST(3), .ADDR_WIDTH(21), .DATA_WIDTH(16), .TO_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .cfg_timeout(cfg_timeout), .cfg_rr_en(cfg_rr_en),
    .mst_paddr(mst_paddr), .mst_psel(mst_psel), .mst_penable(mst_penable),
    .mst_pwrite(mst_pwrite), .mst_pwdata(mst_pwdata), .mst_pready(mst_pready),
    .mst_prdata(mst_prdata),
`ifdef ARB_PSLVERR_EN
    .mst_pslverr(mst_pslverr),
`endif
    .req_addr(req_addr), .req_write(req_write), .req_sel(req_sel), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_rdata(req_rdata), .stat_timeout(stat_timeout),
    .stat_gnt_id(stat_gnt_id)
  );

  typedef struct {
    logic [2:0]  mask;
    bit          rr;
    int          t;
    int          d;
    logic [15:0] rd;
    int          win;
    int          cyc;
    bit          to;
    logic [15:0] prd;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotate the request mask so the search start sits at bit 0; lowest set bit wins.
  function automatic int pick(input logic [2:0] m, input bit rr, input int ptr);
    int base;
    logic [5:0] rot;
    base = rr ? (ptr + 1) % 3 : 0;
    rot = {m, m} >> base;
    for (int j = 0; j < 3; j++)
      if (rot[j]) return (base + j) % 3;
    return -1;
  endfunction

  task automatic post(input int i, input logic [20:0] a, input logic w, input logic [15:0] wd);
    maddr[i] = a; mwrite[i] = w; mwdata[i] = wd;
    mst_paddr[i*21 +: 21]  = a;
    mst_pwdata[i*16 +: 16] = wd;
    mst_pwrite[i]  = w;
    mst_psel[i]    = 1'b1;
    mst_penable[i] = 1'b1;
    pending[i]     = 1'b1;
  endtask

  task automatic post_rand(input int i);
    post(i, 21'($urandom), 1'($urandom), 16'($urandom));
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    mst_paddr = '0; mst_pwdata = '0; mst_psel = '0; mst_penable = '0; mst_pwrite = '0;
    req_ready = 1'b0; req_rdata = '0;
    pending = '0; mptr = 2;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Entered and left 1 time unit after a clock edge with the arbiter in IDLE.
  task automatic do_txn(input int d, input logic [15:0] rd, input int ew, input bit eto,
                        input logic [15:0] eprd, input int ecyc, input bit drop,
                        input bit stray, input logic [2:0] late);
    int cyc;
    bit rr_now;
    logic [2:0] oh;
    rr_now = cfg_rr_en;
    oh = 3'b001 << ew;
    req_ready = stray;
    req_rdata = rd;
    @(negedge clk);
    chk("idle_sel", req_sel, 0);
    chk("idle_pready", mst_pready, 0);
    chk("idle_timeout", stat_timeout, 0);
    @(posedge clk); #1;
    req_ready = (d == 0);
    if (drop) begin mst_psel[ew] = 1'b0; mst_penable[ew] = 1'b0; end
    for (int i = 0; i < 3; i++)
      if (late[i] && !pending[i]) post_rand(i);
    cyc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!req_sel) break;
      cyc++;
      if (cyc == 1) begin
        chk("gnt_id", stat_gnt_id, ew);
        chk("req_addr", req_addr, maddr[ew]);
        chk("req_write", req_write, mwrite[ew]);
        chk("req_wdata", req_wdata, mwdata[ew]);
        chk("access_pready", mst_pready, 0);
      end
      @(posedge clk); #1;
      req_ready = (cyc == ecyc) ? stray : (cyc == d);
    end
    chk("sel_cycles", cyc, ecyc);
    chk("resp_pready", mst_pready, oh);
    chk("resp_prdata", mst_prdata, eprd);
    chk("resp_timeout", stat_timeout, eto);
`ifdef ARB_PSLVERR_EN
    chk("resp_pslverr", mst_pslverr, eto ? oh : 3'b000);
`endif
    @(posedge clk); #1;
    req_ready = 1'b0;
    mst_psel[ew] = 1'b0; mst_penable[ew] = 1'b0; pending[ew] = 1'b0;
    if (rr_now) mptr = ew;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, t, ew, ecyc;
    bit to;
    logic [15:0] rd;

    cfg_timeout = '0; cfg_rr_en = 1'b0;
    apply_reset();
    chk("rst_sel", req_sel, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_write", req_write, 0);
    chk("rst_wdata", req_wdata, 0);
    chk("rst_pready", mst_pready, 0);
    chk("rst_prdata", mst_prdata, 0);
    chk("rst_timeout", stat_timeout, 0);
    chk("rst_gnt", stat_gnt_id, 0);
`ifdef ARB_PSLVERR_EN
    chk("rst_pslverr", mst_pslverr, 0);
`endif

    tbl[0] = '{3'b110, 1'b1, 0, 0, 16'h1111, 1, 1, 1'b0, 16'h1111};
    tbl[1] = '{3'b001, 1'b1, 3, 2, 16'h2222, 2, 3, 1'b0, 16'h2222};
    tbl[2] = '{3'b110, 1'b0, 3, 3, 16'h3333, 0, 3, 1'b1, 16'h0000};
    tbl[3] = '{3'b000, 1'b1, 2, 1, 16'h4444, 1, 2, 1'b0, 16'h4444};
    tbl[4] = '{3'b001, 1'b0, 1, 0, 16'h5555, 0, 1, 1'b0, 16'h5555};
    tbl[5] = '{3'b000, 1'b0, 1, 5, 16'h6666, 2, 1, 1'b1, 16'h0000};
    tbl[6] = '{3'b011, 1'b1, 0, 3, 16'h7777, 0, 4, 1'b0, 16'h7777};
    tbl[7] = '{3'b100, 1'b1, 0, 0, 16'h8888, 1, 1, 1'b0, 16'h8888};
    foreach (tbl[v]) begin
      cfg_rr_en = tbl[v].rr;
      cfg_timeout = 16'(tbl[v].t);
      for (int i = 0; i < 3; i++)
        if (tbl[v].mask[i]) post_rand(i);
      do_txn(tbl[v].d, tbl[v].rd, tbl[v].win, tbl[v].to, tbl[v].prd, tbl[v].cyc, 1'b0, 1'b0, 3'b000);
    end

    // single read from master 1
    apply_reset();
    cfg_rr_en = 1'b0; cfg_timeout = '0;
    post(1, 21'h00123, 1'b0, 16'h0000);
    do_txn(2, 16'hA5A5, 1, 1'b0, 16'hA5A5, 3, 1'b0, 1'b0, 3'b000);

    // fixed priority: master 0 re-requests and starves the others
    apply_reset();
    cfg_rr_en = 1'b0; cfg_timeout = '0;
    post_rand(0); post_rand(1); post_rand(2);
    do_txn(0, 16'h0101, 0, 1'b0, 16'h0101, 1, 1'b0, 1'b0, 3'b000);
    post_rand(0);
    do_txn(0, 16'h0202, 0, 1'b0, 16'h0202, 1, 1'b0, 1'b0, 3'b000);
    do_txn(0, 16'h0303, 1, 1'b0, 16'h0303, 1, 1'b0, 1'b0, 3'b000);
    do_txn(0, 16'h0404, 2, 1'b0, 16'h0404, 1, 1'b0, 1'b0, 3'b000);

    // round-robin with all masters continuously requesting
    apply_reset();
    cfg_rr_en = 1'b1; cfg_timeout = '0;
    post_rand(0); post_rand(1); post_rand(2);
    for (int n = 0; n < 4; n++) begin
      ew = n % 3;
      do_txn(0, 16'(n + 16'h10), ew, 1'b0, 16'(n + 16'h10), 1, 1'b0, 1'b0, 3'b000);
      post_rand(ew);
    end

    // timeout, indefinite wait, same-cycle ready/timeout, psel dropped mid-access
    apply_reset();
    cfg_rr_en = 1'b0; cfg_timeout = 16'd5;
    post_rand(0);
    do_txn(0, 16'h9999, 0, 1'b0, 16'h9999, 1, 1'b0, 1'b0, 3'b000);
    post_rand(2);
    do_txn(100, 16'hDEAD, 2, 1'b1, 16'h0000, 5, 1'b0, 1'b0, 3'b000);
    post_rand(1);
    do_txn(4, 16'hCAFE, 1, 1'b0, 16'hCAFE, 5, 1'b0, 1'b1, 3'b000);
    cfg_timeout = 16'd0;
    post_rand(0);
    do_txn(30, 16'h1234, 0, 1'b0, 16'h1234, 31, 1'b1, 1'b0, 3'b000);

    // reset in the middle of an access
    apply_reset();
    cfg_rr_en = 1'b1; cfg_timeout = '0;
    post(0, 21'h0BEEF, 1'b0, 16'h0000);
    do_txn(0, 16'hBEEF, 0, 1'b0, 16'hBEEF, 1, 1'b0, 1'b0, 3'b000);
    post(1, 21'h1ABCD, 1'b1, 16'h5A5A);
    post(2, 21'h00777, 1'b0, 16'h0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_sel", req_sel, 1);
    chk("rst_pre_gnt", stat_gnt_id, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_sel", req_sel, 0);
    chk("arst_gnt", stat_gnt_id, 0);
    chk("arst_addr", req_addr, 0);
    chk("arst_wdata", req_wdata, 0);
    chk("arst_write", req_write, 0);
    chk("arst_prdata", mst_prdata, 0);
    chk("arst_pready", mst_pready, 0);
    mst_psel[1] = 1'b0; mst_penable[1] = 1'b0; pending[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("arst_hold_pready", mst_pready, 0);
    @(posedge clk); #1 rstn = 1'b1;
    mptr = 2;
    do_txn(1, 16'hC3C3, pick(pending, 1'b1, mptr), 1'b0, 16'hC3C3, 2, 1'b0, 1'b0, 3'b000);

    // random transactions against the model
    apply_reset();
    for (int n = 0; n < 150; n++) begin
      cfg_rr_en = 1'($urandom);
      t = ($urandom % 3 == 0) ? 0 : $urandom_range(1, 6);
      cfg_timeout = 16'(t);
      for (int i = 0; i < 3; i++)
        if (!pending[i] && ($urandom % 2 == 1)) post_rand(i);
      if (pending == 3'b000) post_rand($urandom_range(0, 2));
      d  = $urandom_range(0, 7);
      rd = 16'($urandom);
      ew = pick(pending, cfg_rr_en, mptr);
      to = (t != 0) && (d >= t);
      ecyc = to ? t : d + 1;
      do_txn(d, rd, ew, to, to ? 16'h0000 : rd, ecyc, ($urandom % 4 == 0),
             1'($urandom), 3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
